// File: rtl/div_seq_32.sv
// div_seq_32: sequential 32-bit signed divider (truncating, C semantics).
// One restoring-division step per clock; each trial subtraction goes through
// a single ripple-carry adder computing rem - |divisor| as rem + ~|divisor| + 1.
// Quotient lands on z_lo, remainder on z_hi, 33 clocks after start is accepted.

// 32-bit ripple-carry adder built from a chain of full adders.
module add_rca_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[32];
endmodule

module div_seq_32 (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] z_lo,
  output logic [31:0] z_hi,
  output logic        dbz
);
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [63:0] rq_reg;          // {remainder, quotient} shift register
  logic [31:0] div_mag_reg;     // |divisor|
  logic [31:0] dividend_reg;    // raw dividend, needed for the divide-by-zero result
  logic        q_neg_reg;       // operand signs differ -> negate quotient
  logic        r_neg_reg;       // dividend negative -> negate remainder
  logic        zero_div_reg;    // divisor was zero
  logic [4:0]  count_reg;
  logic [31:0] z_lo_reg, z_hi_reg;
  logic        dbz_reg, done_reg;

  logic [63:0] shifted;
  logic [31:0] trial;
  logic        trial_cout;
  logic [63:0] rq_step;
  logic [31:0] dividend_mag, divisor_mag;
  logic [31:0] quo_fix, rem_fix;

  // Magnitudes of the incoming operands; -2^31 maps to 32'h80000000 unsigned.
  assign dividend_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign divisor_mag  = divisor[31]  ? (~divisor + 32'd1)  : divisor;

  // Trial subtraction on the shifted partial remainder; carry-out 1 means no borrow.
  assign shifted = rq_reg << 1;
  add_rca_32 u_sub (
    .a    (shifted[63:32]),
    .b    (~div_mag_reg),
    .cin  (1'b1),
    .sum  (trial),
    .cout (trial_cout)
  );
  assign rq_step = trial_cout ? {trial, shifted[31:1], 1'b1} : shifted;

  // Sign correction of the unsigned result (truncating division).
  assign quo_fix = q_neg_reg ? (~rq_reg[31:0] + 32'd1) : rq_reg[31:0];
  assign rem_fix = r_neg_reg ? (~rq_reg[63:32] + 32'd1) : rq_reg[63:32];

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: accept in IDLE, 32 iterations, then one fix-up cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ITER;
      ITER:    if (count_reg == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy covers the iteration and fix-up cycles.
  always_comb begin
    busy = 1'b0;
    case (state_reg)
      ITER, FIX: busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // Datapath: latch operands on accept, iterate, then commit results with a done pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      rq_reg       <= 64'd0;
      div_mag_reg  <= 32'd0;
      dividend_reg <= 32'd0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      zero_div_reg <= 1'b0;
      count_reg    <= 5'd0;
      z_lo_reg     <= 32'd0;
      z_hi_reg     <= 32'd0;
      dbz_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            rq_reg       <= {32'd0, dividend_mag};
            div_mag_reg  <= divisor_mag;
            dividend_reg <= dividend;
            q_neg_reg    <= dividend[31] ^ divisor[31];
            r_neg_reg    <= dividend[31];
            zero_div_reg <= (divisor == 32'd0);
            count_reg    <= 5'd0;
          end
        end
        ITER: begin
          rq_reg    <= rq_step;
          count_reg <= count_reg + 5'd1;
        end
        FIX: begin
          done_reg <= 1'b1;
          dbz_reg  <= zero_div_reg;
          if (zero_div_reg) begin
            z_lo_reg <= 32'hFFFF_FFFF;
            z_hi_reg <= dividend_reg;
          end else begin
            z_lo_reg <= quo_fix;
            z_hi_reg <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = done_reg;
  assign z_lo = z_lo_reg;
  assign z_hi = z_hi_reg;
  assign dbz  = dbz_reg;
endmodule

// File: tb/tb_div_seq_32.sv
// tb_div_seq_32: scoreboard bench for div_seq_32. Stimulus pushes the expected
// result (from plain signed arithmetic) and the expected done cycle; a monitor
// pops and compares on every done pulse.
module tb_div_seq_32;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, done, dbz;
  logic [31:0] z_lo, z_hi;

  div_seq_32 dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .z_lo     (z_lo),
    .z_hi     (z_hi),
    .dbz      (dbz)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference: C truncating division with the documented overflow and /0 results.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int due);
    exp_t e;
    int   sa, sbv;
    sa = a;
    sbv = b;
    e.due = due;
    e.a = a;
    e.b = b;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
      e.z = 1'b0;
    end else begin
      e.q = sa / sbv;
      e.r = sa % sbv;
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.due);
        check("z_lo", z_lo, e.q);
        check("z_hi", z_hi, e.r);
        check("dbz", {31'd0, dbz}, {31'd0, e.z});
        $display("op %h / %h -> z_lo=%h z_hi=%h dbz=%0b at cycle %0d", e.a, e.b, z_lo, z_hi, dbz, cyc);
      end
    end
  end

  // Issue one operation from a negedge and return at the negedge of its done cycle,
  // so a following call starts in the done cycle (back-to-back).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit noise);
    int k, nb;
    bit seen;
    dividend = a;
    divisor = b;
    start = 1'b1;
    sb_q.push_back(model(a, b, cyc + 1 + 33));
    @(posedge clock);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    k = 0;
    nb = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clock);
      k++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) nb++;
        start = (noise && (k == 5 || k == 10 || k == 20)) ? 1'b1 : 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_cycles", nb, 32'd33);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges [6];
    logic [31:0] v;
    int sel;
    edges[0] = 32'd0;
    edges[1] = 32'd1;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h7FFF_FFFF;
    edges[5] = 32'h8000_0001;
    sel = $urandom_range(0, 7);
    if (sel == 0)      v = edges[$urandom_range(0, 5)];
    else if (sel == 1) v = 32'($urandom_range(0, 40)) - 32'd20;
    else               v = $urandom;
    return v;
  endfunction

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_z_lo", z_lo, 32'd0);
    check("rst_z_hi", z_hi, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    clear = 1'b0;
    @(negedge clock);

    // Directed cases.
    issue(32'd100, 32'd7, 1'b0);
    issue(-32'd100, 32'd7, 1'b0);
    issue(32'd100, -32'd7, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(32'd0, 32'd5, 1'b0);
    issue(32'd1234, 32'd0, 1'b0);
    issue(32'd9, 32'd3, 1'b0);

    // Starts during an operation are ignored; the next op is issued in the done cycle.
    issue(32'd1000, 32'd33, 1'b1);
    issue(-32'd77, -32'd5, 1'b0);
    issue(32'd5, 32'd0, 1'b0);

    // Clear mid-operation: nothing written, no done pulse follows.
    @(negedge clock);
    dividend = 32'd500;
    divisor = 32'd3;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (16) @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_z_lo", z_lo, 32'd0);
    check("clr_z_hi", z_hi, 32'd0);
    check("clr_dbz", {31'd0, dbz}, 32'd0);
    repeat (40) @(negedge clock);

    // Start together with clear is dropped.
    dividend = 32'd50;
    divisor = 32'd2;
    start = 1'b1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    clear = 1'b0;
    @(negedge clock);
    check("clr_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clock);

    // Randomized signed sweep, back-to-back.
    for (int i = 0; i < 1500; i++) begin
      issue(pick(), pick(), 1'b0);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
